tri_bus_arbiter: RTL and testbench

Sequencer and arbiter for the shared tristate output net driven by the team's controlled-inverter / controlled-NAND drivers. It grants the net to one of N requesters at a time and drives the per-driver enable lines with break-before-make dead-time. It also holds off the grant until the enabled driver's switch-level delays have settled. It sits between the clocked control logic and the enable inputs of the tristate gate cells.

---
 rtl/tri_bus_pkg.sv | 19 +
 rtl/rr_pick.sv | 28 ++
 rtl/tri_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_tri_bus_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tri_bus_pkg.sv
// rtl/tri_bus_pkg.sv - shared state type and width helper for the tristate bus arbiter
package tri_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      OWN,
      DEAD
   } tb_state_t;

   // Bits needed to index `value` distinct codes, never less than one.
   function automatic int clog2_min1(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational circular priority picker starting just above last_owner
module rr_pick #(
   parameter int N  = 2,
   parameter int OW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [OW-1:0] last_owner,
   output logic          pick_valid,
   output logic [OW-1:0] pick_idx
);

   int j;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      j          = 0;
      for (int i = 1; i <= N; i++) begin
         j = int'(last_owner) + i;
         if (j >= N) j = j - N;
         if (!pick_valid && req[j]) begin
            pick_valid = 1'b1;
            pick_idx   = OW'(j);
         end
      end
   end

endmodule

// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - round-robin owner sequencer for a shared tristate net
// Break-before-make enables with settle delay before grant and a bounded tenure.
module tri_bus_arbiter #(
   parameter int N        = 2,
   parameter int DEAD     = 2,
   parameter int SETTLE   = 3,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         en,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy
);

   import tri_bus_pkg::*;

   localparam int OW   = $clog2(N);
   localparam int CMAX = (DEAD > SETTLE) ? ((DEAD > MAX_HOLD) ? DEAD : MAX_HOLD)
                                         : ((SETTLE > MAX_HOLD) ? SETTLE : MAX_HOLD);
   localparam int CW   = clog2_min1(CMAX + 1);

   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);
   localparam logic [CW-1:0] DEAD_LD   = CW'(DEAD);
   localparam logic [CW-1:0] HOLD_LIM  = CW'(MAX_HOLD);
   localparam logic [CW-1:0] TEN_SAT   = (MAX_HOLD == 0) ? {CW{1'b1}} : CW'(MAX_HOLD);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [N-1:0]  ONE_HOT0  = N'(1);

   tb_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] ten_q, ten_d;
   logic [OW-1:0] last_q, last_d;
   logic [N-1:0]  en_d, gnt_d;
   logic [OW-1:0] owner_d;
   logic          busy_d;

   logic          pick_valid;
   logic [OW-1:0] pick_idx;
   logic          own_req;
   logic          others_req;
   logic [CW-1:0] ten_inc;
   logic          preempt;

   rr_pick #(
      .N  (N),
      .OW (OW)
   ) u_pick (
      .req        (req),
      .last_owner (last_q),
      .pick_valid (pick_valid),
      .pick_idx   (pick_idx)
   );

   // en is one-hot on the owner, so masking req with it isolates req[owner].
   assign own_req    = |(req & en);
   assign others_req = |(req & ~en);

   // Tenure is judged on the post-increment value so release lands exactly MAX_HOLD edges after grant.
   assign ten_inc = (ten_q == TEN_SAT) ? ten_q : ten_q + 1'b1;
   assign preempt = (MAX_HOLD != 0) && (ten_inc == HOLD_LIM) && others_req;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ten_d   = ten_q;
      last_d  = last_q;
      en_d    = en;
      gnt_d   = gnt;
      owner_d = owner;
      busy_d  = busy;
      case (state_q)
         tri_bus_pkg::IDLE: begin
            en_d    = '0;
            gnt_d   = '0;
            owner_d = '0;
            busy_d  = 1'b0;
            if (pick_valid) begin
               en_d    = ONE_HOT0 << pick_idx;
               owner_d = pick_idx;
               busy_d  = 1'b1;
               cnt_d   = SETTLE_LD;
               state_d = tri_bus_pkg::SETTLE;
            end
         end
         tri_bus_pkg::SETTLE: begin
            if (!own_req) begin
               en_d    = '0;
               gnt_d   = '0;
               owner_d = '0;
               busy_d  = 1'b0;
               last_d  = owner;
               cnt_d   = DEAD_LD;
               state_d = tri_bus_pkg::DEAD;
            end else if (cnt_q <= CNT_ONE) begin
               cnt_d   = '0;
               gnt_d   = en;
               ten_d   = '0;
               state_d = tri_bus_pkg::OWN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         tri_bus_pkg::OWN: begin
            ten_d = ten_inc;
            if (!own_req || preempt) begin
               en_d    = '0;
               gnt_d   = '0;
               owner_d = '0;
               busy_d  = 1'b0;
               last_d  = owner;
               cnt_d   = DEAD_LD;
               state_d = tri_bus_pkg::DEAD;
            end
         end
         tri_bus_pkg::DEAD: begin
            en_d    = '0;
            gnt_d   = '0;
            owner_d = '0;
            busy_d  = 1'b0;
            if (cnt_q <= CNT_ONE) begin
               cnt_d   = '0;
               state_d = tri_bus_pkg::IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            en_d    = '0;
            gnt_d   = '0;
            owner_d = '0;
            busy_d  = 1'b0;
            state_d = tri_bus_pkg::IDLE;
         end
      endcase
   end

   // Reset puts priority on requester 0 by pretending N-1 owned last.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= tri_bus_pkg::IDLE;
         cnt_q   <= '0;
         ten_q   <= '0;
         last_q  <= OW'(N - 1);
         en      <= '0;
         gnt     <= '0;
         owner   <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ten_q   <= ten_d;
         last_q  <= last_d;
         en      <= en_d;
         gnt     <= gnt_d;
         owner   <= owner_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb/tb_tri_bus_arbiter.sv - self-checking bench for tri_bus_arbiter
module tb_tri_bus_arbiter;

   localparam int N        = 2;
   localparam int DEAD     = 2;
   localparam int SETTLE   = 3;
   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic [1:0] en;
   logic [1:0] gnt;
   logic [0:0] owner;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   tri_bus_arbiter #(
      .N        (N),
      .DEAD     (DEAD),
      .SETTLE   (SETTLE),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .en    (en),
      .gnt   (gnt),
      .owner (owner),
      .busy  (busy)
   );

   typedef struct {
      logic       rst;
      logic [1:0] req;
      logic [1:0] en;
      logic [1:0] gnt;
      logic       owner;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input int n, input logic r, input logic [1:0] q,
                               input logic [1:0] e, input logic [1:0] g, input logic o);
      vec_t v;
      v.rst   = r;
      v.req   = q;
      v.en    = e;
      v.gnt   = g;
      v.owner = o;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [1:0] e, input logic [1:0] g, input logic o);
      check({tag, ".en"},    32'(en),    32'(e));
      check({tag, ".gnt"},   32'(gnt),   32'(g));
      check({tag, ".owner"}, 32'(owner), 32'(o));
      check({tag, ".busy"},  32'(busy),  32'(|e));
   endtask

   // Inputs change at the falling edge; outputs are examined at the next falling edge.
   task automatic tick(input logic r, input logic [1:0] q);
      rst = r;
      req = q;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Timeline model: owner, enable edge and earliest free edge, all in absolute edge numbers.
   int m_owner, m_last, m_en_edge, m_free;

   task automatic model_step(input logic r, input logic [1:0] q, input int e);
      int k, g;
      logic found;
      if (r) begin
         m_owner = -1;
         m_last  = N - 1;
         m_free  = e + 1;
      end else if (m_owner < 0) begin
         found = 1'b0;
         if (e >= m_free) begin
            for (int i = 1; i <= N; i++) begin
               k = (m_last + i) % N;
               if (!found && q[k]) begin
                  found     = 1'b1;
                  m_owner   = k;
                  m_en_edge = e;
               end
            end
         end
      end else begin
         g = m_en_edge + SETTLE;
         if (!q[m_owner] ||
             (MAX_HOLD != 0 && e - g >= MAX_HOLD && (q & ~(2'b01 << m_owner)) != 2'b00)) begin
            m_last  = m_owner;
            m_owner = -1;
            m_free  = e + DEAD + 1;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0] q, exp_en, exp_gnt, prev_en;
      logic       r, exp_o, seen;
      int         zero_run;

      // Reset with both requesting, then alternating preemption.
      add(2, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0);
      add(3, 1'b0, 2'b11, 2'b01, 2'b00, 1'b0);
      add(8, 1'b0, 2'b11, 2'b01, 2'b01, 1'b0);
      add(3, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
      add(3, 1'b0, 2'b11, 2'b10, 2'b00, 1'b1);
      add(8, 1'b0, 2'b11, 2'b10, 2'b10, 1'b1);
      add(3, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
      add(1, 1'b0, 2'b11, 2'b01, 2'b00, 1'b0);
      // Single grant, release, then the other requester after the dead time.
      add(2,  1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
      add(10, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
      add(3,  1'b0, 2'b01, 2'b01, 2'b00, 1'b0);
      add(7,  1'b0, 2'b01, 2'b01, 2'b01, 1'b0);
      add(3,  1'b0, 2'b10, 2'b00, 2'b00, 1'b0);
      add(1,  1'b0, 2'b10, 2'b10, 2'b00, 1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         tick(vecs[i].rst, vecs[i].req);
         check_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].gnt, vecs[i].owner);
      end

      // Abort during settle, then re-request.
      tick(1'b1, 2'b00);
      tick(1'b0, 2'b01); check_outs("abort.e0", 2'b01, 2'b00, 1'b0);
      tick(1'b0, 2'b01); check_outs("abort.e1", 2'b01, 2'b00, 1'b0);
      tick(1'b0, 2'b00); check_outs("abort.e2", 2'b00, 2'b00, 1'b0);
      tick(1'b0, 2'b01); check_outs("abort.e3", 2'b00, 2'b00, 1'b0);
      tick(1'b0, 2'b01); check_outs("abort.e4", 2'b00, 2'b00, 1'b0);
      tick(1'b0, 2'b01); check_outs("abort.e5", 2'b01, 2'b00, 1'b0);
      tick(1'b0, 2'b01); check_outs("abort.e6", 2'b01, 2'b00, 1'b0);
      tick(1'b0, 2'b01); check_outs("abort.e7", 2'b01, 2'b00, 1'b0);
      tick(1'b0, 2'b01); check_outs("abort.e8", 2'b01, 2'b01, 1'b0);

      // Lone requester is never preempted.
      tick(1'b1, 2'b00);
      for (int e = 0; e < 30; e++) begin
         tick(1'b0, 2'b01);
         check_outs($sformatf("solo.e%0d", e), 2'b01, (e >= SETTLE) ? 2'b01 : 2'b00, 1'b0);
      end

      // Reset in the middle of ownership: immediate clear, no dead time afterwards.
      tick(1'b1, 2'b00);
      for (int e = 0; e < 6; e++) tick(1'b0, 2'b11);
      check_outs("midrst.own", 2'b01, 2'b01, 1'b0);
      tick(1'b1, 2'b11); check_outs("midrst.rst", 2'b00, 2'b00, 1'b0);
      tick(1'b0, 2'b11); check_outs("midrst.re", 2'b01, 2'b00, 1'b0);

      // Random requests and occasional resets against the timeline model.
      q        = 2'b00;
      seen     = 1'b0;
      zero_run = 0;
      prev_en  = 2'b00;
      for (int e = 0; e < 2000; e++) begin
         r = (e == 0) || ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 5) == 0) q = 2'($urandom_range(0, 3));
         tick(r, q);
         model_step(r, q, e);
         exp_en  = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
         exp_gnt = (m_owner >= 0 && e >= m_en_edge + SETTLE) ? exp_en : 2'b00;
         exp_o   = (m_owner >= 0) ? 1'(m_owner) : 1'b0;
         check_outs($sformatf("rnd%0d", e), exp_en, exp_gnt, exp_o);
         check($sformatf("rnd%0d.onehot", e), 32'($onehot0(en)), 32'd1);
         check($sformatf("rnd%0d.gnt_en", e), 32'((gnt & ~en) == 2'b00), 32'd1);
         if (r) begin
            check($sformatf("rnd%0d.rst_clr", e), 32'({en, gnt, owner, busy}), 32'd0);
            seen     = 1'b0;
            zero_run = 0;
         end else if (en == 2'b00) begin
            zero_run++;
         end else begin
            if (seen && prev_en == 2'b00)
               check($sformatf("rnd%0d.gap", e), 32'(zero_run >= DEAD + 1), 32'd1);
            seen     = 1'b1;
            zero_run = 0;
         end
         prev_en = en;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
